// File: rtl/llama_layer_mul_arb.sv
// Round-robin arbiter that shares one external 22x22 multiplier among NUM_REQ requesters.
// Stage S1 drives the multiplier operands; stage S2 captures the product for the response channel.
module llama_layer_mul_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int OP_W    = 22,
  parameter int RES_W   = 44
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*OP_W-1:0] req_a,
  input  logic [NUM_REQ*OP_W-1:0] req_b,
  output logic [OP_W-1:0]         mul_din0,
  output logic [OP_W-1:0]         mul_din1,
  input  logic [RES_W-1:0]        mul_dout,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [RES_W-1:0]        rsp_data,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    busy
);

  logic              s1Valid_q, s1Valid_d;
  logic [ID_W-1:0]   s1Id_q, s1Id_d;
  logic [OP_W-1:0]   din0_q, din0_d;
  logic [OP_W-1:0]   din1_q, din1_d;
  logic              s2Valid_q, s2Valid_d;
  logic [RES_W-1:0]  rspData_q, rspData_d;
  logic [ID_W-1:0]   rspId_q, rspId_d;
  logic [ID_W-1:0]   rrPtr_q, rrPtr_d;

  logic              s2Adv;
  logic              s1Adv;
  logic              grantValid;
  logic [ID_W-1:0]   grantIdx;
  logic [OP_W-1:0]   grantA;
  logic [OP_W-1:0]   grantB;
  logic              accept;
  logic [ID_W:0]     scanSum;
  logic [ID_W-1:0]   scanIdx;

  assign s2Adv = !s2Valid_q || rsp_ready;
  assign s1Adv = !s1Valid_q || s2Adv;

  // Scan from the round-robin pointer upward, wrapping at NUM_REQ, and take the first valid requester.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    grantA     = '0;
    grantB     = '0;
    scanSum    = '0;
    scanIdx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scanSum = {1'b0, rrPtr_q} + (ID_W+1)'(k);
      if (scanSum >= (ID_W+1)'(NUM_REQ)) begin
        scanSum = scanSum - (ID_W+1)'(NUM_REQ);
      end
      scanIdx = scanSum[ID_W-1:0];
      if (!grantValid && req_valid[scanIdx]) begin
        grantValid = 1'b1;
        grantIdx   = scanIdx;
        grantA     = req_a[scanIdx*OP_W +: OP_W];
        grantB     = req_b[scanIdx*OP_W +: OP_W];
      end
    end
  end

  assign accept    = grantValid && s1Adv && !ap_rst;
  assign req_ready = accept ? (NUM_REQ'(1) << grantIdx) : '0;

  always_comb begin
    s1Valid_d = s1Valid_q;
    s1Id_d    = s1Id_q;
    din0_d    = din0_q;
    din1_d    = din1_q;
    s2Valid_d = s2Valid_q;
    rspData_d = rspData_q;
    rspId_d   = rspId_q;
    rrPtr_d   = rrPtr_q;

    // Operands stay parked on the multiplier when nothing new is granted.
    if (accept) begin
      s1Valid_d = 1'b1;
      s1Id_d    = grantIdx;
      din0_d    = grantA;
      din1_d    = grantB;
      rrPtr_d   = (int'(grantIdx) == NUM_REQ-1) ? '0 : grantIdx + 1'b1;
    end else if (s1Adv) begin
      s1Valid_d = 1'b0;
    end

    if (s2Adv && s1Valid_q) begin
      s2Valid_d = 1'b1;
      rspData_d = mul_dout;
      rspId_d   = s1Id_q;
    end else if (rsp_ready) begin
      s2Valid_d = 1'b0;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s1Valid_q <= 1'b0;
      s1Id_q    <= '0;
      din0_q    <= '0;
      din1_q    <= '0;
      s2Valid_q <= 1'b0;
      rspData_q <= '0;
      rspId_q   <= '0;
      rrPtr_q   <= '0;
    end else begin
      s1Valid_q <= s1Valid_d;
      s1Id_q    <= s1Id_d;
      din0_q    <= din0_d;
      din1_q    <= din1_d;
      s2Valid_q <= s2Valid_d;
      rspData_q <= rspData_d;
      rspId_q   <= rspId_d;
      rrPtr_q   <= rrPtr_d;
    end
  end

  assign mul_din0  = din0_q;
  assign mul_din1  = din1_q;
  assign rsp_valid = s2Valid_q;
  assign rsp_data  = rspData_q;
  assign rsp_id    = rspId_q;
  assign busy      = s1Valid_q || s2Valid_q;

endmodule

// File: tb/tb_llama_layer_mul_arb.sv
// Scoreboard bench for llama_layer_mul_arb: a driver predicts grants and products from a
// two-slot in-flight FIFO model, and a separate monitor checks every response against it.
module tb_llama_layer_mul_arb;

  localparam int N    = 4;
  localparam int IDW  = 2;
  localparam int OPW  = 22;
  localparam int RESW = 44;

  typedef struct {
    int               id;
    logic [RESW-1:0]  data;
    int               acc;
  } expEntry_t;

  logic                ap_clk;
  logic                ap_rst;
  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_ready;
  logic [N*OPW-1:0]    req_a;
  logic [N*OPW-1:0]    req_b;
  logic [OPW-1:0]      mul_din0;
  logic [OPW-1:0]      mul_din1;
  logic [RESW-1:0]     mul_dout;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [RESW-1:0]     rsp_data;
  logic [IDW-1:0]      rsp_id;
  logic                busy;

  expEntry_t           expQ[$];
  int                  modelPtr = 0;
  logic [OPW-1:0]      modelDin0 = '0;
  logic [OPW-1:0]      modelDin1 = '0;
  int                  edgeCount = 0;
  bit                  started = 0;
  int                  nChecks = 0;
  int                  nFails = 0;

  llama_layer_mul_arb #(.NUM_REQ(N), .ID_W(IDW), .OP_W(OPW), .RES_W(RESW)) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_din0  (mul_din0),
    .mul_din1  (mul_din1),
    .mul_dout  (mul_dout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  // Behavioural stand-in for the shared combinational multiplier.
  assign mul_dout = RESW'(mul_din0) * RESW'(mul_din1);

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) edgeCount <= edgeCount + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edgeCount);
    end
  endtask

  // Drives one cycle of inputs and predicts the grant: a new pair fits when fewer than two
  // products are in flight, or when the consumer takes the oldest one this cycle.
  task automatic applyStimulus(input logic rst, input logic rdy, input logic [N-1:0] v,
                               input logic [N*OPW-1:0] a, input logic [N*OPW-1:0] b);
    logic [N-1:0]   expReady;
    logic [OPW-1:0] ga;
    logic [OPW-1:0] gb;
    expEntry_t      e;
    int             g;
    int             idx;
    @(negedge ap_clk);
    ap_rst    = rst;
    rsp_ready = rdy;
    req_valid = v;
    req_a     = a;
    req_b     = b;
    #1;
    checkOutput("mul_din0", 64'(mul_din0), 64'(modelDin0));
    checkOutput("mul_din1", 64'(mul_din1), 64'(modelDin1));
    checkOutput("busy", 64'(busy), 64'(expQ.size() != 0));
    expReady = '0;
    g = -1;
    if (rst) begin
      expQ.delete();
      modelPtr  = 0;
      modelDin0 = '0;
      modelDin1 = '0;
    end else if (expQ.size() < 2 || rdy) begin
      for (int k = 0; k < N; k++) begin
        idx = (modelPtr + k) % N;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    if (g >= 0) expReady[g] = 1'b1;
    checkOutput("req_ready", 64'(req_ready), 64'(expReady));
    if (g >= 0) begin
      ga     = a[g*OPW +: OPW];
      gb     = b[g*OPW +: OPW];
      e.id   = g;
      e.data = RESW'(ga) * RESW'(gb);
      e.acc  = edgeCount + 1;
      expQ.push_back(e);
      modelPtr  = (g + 1) % N;
      modelDin0 = ga;
      modelDin1 = gb;
    end
  endtask

  function automatic logic [OPW-1:0] randOp();
    logic [OPW-1:0] r;
    case ($urandom_range(0, 7))
      0:       r = '0;
      1:       r = '1;
      default: r = OPW'($urandom);
    endcase
    return r;
  endfunction

  // Monitor: a product becomes visible one edge after the edge that accepted it, in order.
  initial begin
    bit vis;
    forever begin
      @(negedge ap_clk);
      #4;
      if (started && !ap_rst) begin
        vis = (expQ.size() > 0) && (expQ[0].acc < edgeCount);
        checkOutput("rsp_valid", 64'(rsp_valid), 64'(vis));
        if (vis) begin
          checkOutput("rsp_id", 64'(rsp_id), 64'(expQ[0].id));
          checkOutput("rsp_data", 64'(rsp_data), 64'(expQ[0].data));
          if (rsp_ready) void'(expQ.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [N*OPW-1:0] pa;
    logic [N*OPW-1:0] pb;
    ap_rst    = 1'b1;
    rsp_ready = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    #1;
    checkOutput("reset rsp_valid", 64'(rsp_valid), 64'(0));
    checkOutput("reset busy", 64'(busy), 64'(0));
    checkOutput("reset rsp_data", 64'(rsp_data), 64'(0));
    checkOutput("reset rsp_id", 64'(rsp_id), 64'(0));
    checkOutput("reset mul_din0", 64'(mul_din0), 64'(0));
    checkOutput("reset mul_din1", 64'(mul_din1), 64'(0));
    checkOutput("reset req_ready", 64'(req_ready), 64'(0));
    started = 1;

    $display("[TB] single request");
    pa = '0; pb = '0;
    pa[2*OPW +: OPW] = 22'd1000;
    pb[2*OPW +: OPW] = 22'd3000;
    applyStimulus(1'b0, 1'b1, 4'b0100, pa, pb);
    repeat (3) applyStimulus(1'b0, 1'b1, 4'b0000, pa, pb);

    $display("[TB] round robin");
    for (int c = 0; c < 12; c++) begin
      for (int k = 0; k < N; k++) begin
        pa[k*OPW +: OPW] = OPW'(100 * c + k + 1);
        pb[k*OPW +: OPW] = OPW'(7 * c + 3 * k + 2);
      end
      applyStimulus(1'b0, 1'b1, 4'b1111, pa, pb);
    end
    repeat (3) applyStimulus(1'b0, 1'b1, 4'b0000, pa, pb);

    $display("[TB] max operands");
    pa = '0; pb = '0;
    pa[1*OPW +: OPW] = '1;
    pb[1*OPW +: OPW] = '1;
    applyStimulus(1'b0, 1'b1, 4'b0010, pa, pb);
    pa[1*OPW +: OPW] = '0;
    applyStimulus(1'b0, 1'b1, 4'b0010, pa, pb);
    repeat (3) applyStimulus(1'b0, 1'b1, 4'b0000, pa, pb);

    $display("[TB] backpressure");
    for (int k = 0; k < N; k++) begin
      pa[k*OPW +: OPW] = OPW'(5000 + k);
      pb[k*OPW +: OPW] = OPW'(9000 + 11 * k);
    end
    applyStimulus(1'b0, 1'b0, 4'b0100, pa, pb);
    applyStimulus(1'b0, 1'b0, 4'b1000, pa, pb);
    repeat (5) applyStimulus(1'b0, 1'b0, 4'b1111, pa, pb);
    repeat (4) applyStimulus(1'b0, 1'b1, 4'b0000, pa, pb);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b0, 1'b0, 4'b0001, pa, pb);
    applyStimulus(1'b0, 1'b0, 4'b0010, pa, pb);
    applyStimulus(1'b0, 1'b0, 4'b1111, pa, pb);
    applyStimulus(1'b1, 1'b0, 4'b1111, pa, pb);
    applyStimulus(1'b1, 1'b1, 4'b1111, pa, pb);
    applyStimulus(1'b0, 1'b1, 4'b1111, pa, pb);
    repeat (3) applyStimulus(1'b0, 1'b1, 4'b0000, pa, pb);

    $display("[TB] pointer wrap");
    applyStimulus(1'b0, 1'b1, 4'b1000, pa, pb);
    applyStimulus(1'b0, 1'b1, 4'b0001, pa, pb);
    applyStimulus(1'b0, 1'b1, 4'b0001, pa, pb);
    repeat (3) applyStimulus(1'b0, 1'b1, 4'b0000, pa, pb);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        pa[k*OPW +: OPW] = randOp();
        pb[k*OPW +: OPW] = randOp();
      end
      applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                    N'($urandom), pa, pb);
    end
    repeat (6) applyStimulus(1'b0, 1'b1, 4'b0000, pa, pb);

    @(negedge ap_clk);
    #6;
    checkOutput("drained scoreboard", 64'(expQ.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
